// File: rtl/usb_tx.sv
// USB full-speed transmit serializer: SYNC, PID, optional DATA0 payload and CRC16,
// NRZI-encoded with bit stuffing, closed by SE0/SE0/J end-of-packet.
module usb_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_transfer_active,
    output logic       tx_error
);
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] MAX_B = 8'(MAX_BYTES);

    // state/idx point at the next field bit to send, not the one on the line
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SYNC    = 3'd1;
    localparam logic [2:0] S_PID     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CRC     = 3'd4;
    localparam logic [2:0] S_EOP     = 3'd5;

    logic [2:0]    state;
    logic [3:0]    idx;
    logic [TW-1:0] timer;
    logic [7:0]    pid_byte;
    logic [7:0]    data_byte;
    logic [6:0]    bytes_left;
    logic          is_data0;
    logic [15:0]   crc;
    logic [2:0]    ones;
    logic          line;
    logic          fetch_bit;

    function automatic logic [7:0] pid_of(input logic [2:0] code);
        case (code)
            3'd1:    pid_of = 8'hC3;
            3'd2:    pid_of = 8'hD2;
            3'd3:    pid_of = 8'h5A;
            3'd4:    pid_of = 8'h1E;
            default: pid_of = 8'h00;
        endcase
    endfunction

    logic legal_code, too_long, start_req, err_req;
    assign legal_code = (tx_packet >= 3'd1) && (tx_packet <= 3'd4);
    assign too_long   = (tx_packet == 3'd1) && ({1'b0, buffer_occupancy} > MAX_B);
    assign start_req  = !tx_transfer_active && legal_code && !too_long;
    assign err_req    = !tx_transfer_active && too_long;

    // Buffer handshake: get_tx_packet_data is high for one cycle while
    // tx_packet_data already shows the byte; it is consumed at the edge ending that cycle.
    logic        stuff, cur_bit, se0, jbit, finish, fetch, payload_bit, fb;
    logic [2:0]  adv_state;
    logic [3:0]  adv_idx;
    logic [7:0]  byte_src;
    logic [15:0] crc_nxt;

    always_comb begin
        stuff       = (ones == 3'd6);
        cur_bit     = 1'b0;
        se0         = 1'b0;
        jbit        = 1'b0;
        finish      = 1'b0;
        fetch       = 1'b0;
        payload_bit = 1'b0;
        adv_state   = state;
        adv_idx     = idx + 4'd1;
        byte_src    = get_tx_packet_data ? tx_packet_data : data_byte;
        case (state)
            S_SYNC: begin
                cur_bit = (idx == 4'd7);
                if (idx == 4'd7) begin
                    adv_state = S_PID;
                    adv_idx   = 4'd0;
                end
            end
            S_PID: begin
                cur_bit = pid_byte[idx[2:0]];
                if (idx == 4'd7) begin
                    adv_idx = 4'd0;
                    if (!is_data0) begin
                        adv_state = S_EOP;
                    end else if (bytes_left != 7'd0) begin
                        adv_state = S_PAYLOAD;
                        fetch     = 1'b1;
                    end else begin
                        adv_state = S_CRC;
                    end
                end
            end
            S_PAYLOAD: begin
                cur_bit     = byte_src[idx[2:0]];
                payload_bit = 1'b1;
                if (idx == 4'd7) begin
                    adv_idx = 4'd0;
                    if (bytes_left != 7'd0) fetch = 1'b1;
                    else adv_state = S_CRC;
                end
            end
            S_CRC: begin
                cur_bit = ~crc[idx];
                if (idx == 4'd15) begin
                    adv_state = S_EOP;
                    adv_idx   = 4'd0;
                end
            end
            S_EOP: begin
                if (idx < 4'd2) se0 = 1'b1;
                else if (idx == 4'd2) jbit = 1'b1;
                else finish = 1'b1;
            end
            default: ;
        endcase
        fb      = cur_bit ^ crc[0];
        crc_nxt = {1'b0, crc[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= S_IDLE;
            idx                <= 4'd0;
            timer              <= '0;
            pid_byte           <= 8'h00;
            data_byte          <= 8'h00;
            bytes_left         <= 7'd0;
            is_data0           <= 1'b0;
            crc                <= 16'hFFFF;
            ones               <= 3'd0;
            line               <= 1'b1;
            fetch_bit          <= 1'b0;
            get_tx_packet_data <= 1'b0;
            dplus_out          <= 1'b1;
            dminus_out         <= 1'b0;
            tx_transfer_active <= 1'b0;
            tx_error           <= 1'b0;
        end else begin
            tx_error           <= 1'b0;
            get_tx_packet_data <= 1'b0;
            if (!tx_transfer_active) begin
                timer <= '0;
                if (start_req) begin
                    // first SYNC bit is a 0: the line toggles J -> K right away
                    tx_transfer_active <= 1'b1;
                    state              <= S_SYNC;
                    idx                <= 4'd1;
                    line               <= 1'b0;
                    dplus_out          <= 1'b0;
                    dminus_out         <= 1'b1;
                    ones               <= 3'd0;
                    crc                <= 16'hFFFF;
                    pid_byte           <= pid_of(tx_packet);
                    is_data0           <= (tx_packet == 3'd1);
                    bytes_left         <= buffer_occupancy;
                    fetch_bit          <= 1'b0;
                end else if (err_req) begin
                    tx_error <= 1'b1;
                end
            end else if (timer == T_LAST) begin
                timer <= '0;
                if (get_tx_packet_data) begin
                    data_byte  <= tx_packet_data;
                    bytes_left <= bytes_left - 7'd1;
                end
                if (stuff) begin
                    line       <= ~line;
                    dplus_out  <= ~line;
                    dminus_out <= line;
                    ones       <= 3'd0;
                    fetch_bit  <= 1'b0;
                end else if (finish) begin
                    tx_transfer_active <= 1'b0;
                    state              <= S_IDLE;
                    idx                <= 4'd0;
                    fetch_bit          <= 1'b0;
                end else if (se0) begin
                    dplus_out  <= 1'b0;
                    dminus_out <= 1'b0;
                    ones       <= 3'd0;
                    idx        <= adv_idx;
                    fetch_bit  <= 1'b0;
                end else if (jbit) begin
                    line       <= 1'b1;
                    dplus_out  <= 1'b1;
                    dminus_out <= 1'b0;
                    idx        <= adv_idx;
                    fetch_bit  <= 1'b0;
                end else begin
                    line       <= cur_bit ? line : ~line;
                    dplus_out  <= cur_bit ? line : ~line;
                    dminus_out <= cur_bit ? ~line : line;
                    ones       <= cur_bit ? ones + 3'd1 : 3'd0;
                    if (payload_bit) crc <= crc_nxt;
                    state              <= adv_state;
                    idx                <= adv_idx;
                    fetch_bit          <= fetch;
                    get_tx_packet_data <= fetch && (CLKS_PER_BIT == 1);
                end
            end else begin
                timer              <= timer + 1'b1;
                get_tx_packet_data <= fetch_bit && ((timer + 1'b1) == T_LAST);
            end
        end
    end
endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: table of packet requests decoded by a bench-side
// NRZI/destuff receiver, plus sequences for overflow, ignored codes, reset and busy.
module tb_usb_tx;
    localparam int CPB = 8;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic [2:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_transfer_active;
    logic       tx_error;

    usb_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(64)) dut (
        .clk                (tb_clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error)
    );

    always #5 tb_clk = ~tb_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  pkt;
        logic [6:0]  occ;
        logic [7:0]  b0, b1, b2;
        logic [7:0]  exp_pid;
        int          exp_bits;
        int          exp_gets;
        int          exp_stuffs;
        logic [15:0] exp_crc;
        int          exp_first_get;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] pay[0:3];
    logic [1:0] syms[0:1023];
    int         n_sym, n_get, act_cycles, err_seen;
    int         get_k[0:7];

    logic [7:0]  dec_sync, dec_pid;
    logic [7:0]  dec_bytes[0:7];
    logic [15:0] dec_crc;
    int          dec_nbits, dec_nbytes, dec_stuffs, dec_stuff_err;
    logic        dec_eop_ok;

    // Issue one request, then follow the packet until tx_transfer_active drops.
    task automatic run_packet(input logic [2:0] pkt, input logic [6:0] occ,
                              input int inject_at, input logic [2:0] inject_pkt);
        int k;
        bit done;
        n_sym = 0; n_get = 0; err_seen = 0; k = 0; done = 0;
        @(negedge tb_clk);
        tx_packet_data   = pay[0];
        tx_packet        = pkt;
        buffer_occupancy = occ;
        @(negedge tb_clk);
        tx_packet = 3'd0;
        while (!done) begin
            if (tx_error) err_seen++;
            if (tx_transfer_active && k < 4000) begin
                if (k % CPB == 3) begin
                    syms[n_sym] = {dplus_out, dminus_out};
                    n_sym++;
                end
                tx_packet_data = pay[(n_get < 4) ? n_get : 3];
                if (get_tx_packet_data) begin
                    if (n_get < 8) get_k[n_get] = k;
                    n_get++;
                end
                k++;
                tx_packet = (k == inject_at) ? inject_pkt : 3'd0;
                @(negedge tb_clk);
            end else begin
                done = 1;
            end
        end
        tx_packet = 3'd0;
        check("packet_bound", (k >= 4000), 0);
        act_cycles = k;
    endtask

    task automatic decode();
        logic [1:0] prev;
        logic       b;
        int         ones, i, nb;
        logic       bits[0:1023];
        prev = 2'b10; ones = 0; nb = 0; i = 0;
        dec_stuffs = 0; dec_stuff_err = 0;
        while (i < n_sym && syms[i] != 2'b00) begin
            b    = (syms[i] == prev);
            prev = syms[i];
            if (ones == 6) begin
                dec_stuffs++;
                if (b) dec_stuff_err++;
                ones = 0;
            end else begin
                bits[nb] = b;
                nb++;
                ones = b ? ones + 1 : 0;
            end
            i++;
        end
        dec_eop_ok = 1'b0;
        if (i + 3 == n_sym)
            dec_eop_ok = (syms[i] == 2'b00) && (syms[i+1] == 2'b00) && (syms[i+2] == 2'b10);
        dec_nbits = nb;
        dec_sync = 8'h00; dec_pid = 8'h00; dec_crc = 16'h0000; dec_nbytes = 0;
        for (int j = 0; j < 8; j++) begin
            if (j < nb) dec_sync[j] = bits[j];
            if (j + 8 < nb) dec_pid[j] = bits[j+8];
        end
        if (nb >= 32) begin
            dec_nbytes = (nb - 32) / 8;
            for (int j = 0; j < dec_nbytes && j < 8; j++)
                for (int m = 0; m < 8; m++) dec_bytes[j][m] = bits[16 + 8*j + m];
            for (int m = 0; m < 16; m++) dec_crc[m] = bits[nb - 16 + m];
        end
    endtask

    function automatic logic [15:0] crc16_model(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int j = 0; j < n; j++)
            for (int m = 0; m < 8; m++)
                c = (c[0] ^ pay[j][m]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return ~c;
    endfunction

    task automatic watch(input int n, output int e, output int a, output int nj, output int g);
        e = 0; a = 0; nj = 0; g = 0;
        for (int c = 0; c < n; c++) begin
            if (tx_error) e++;
            if (tx_transfer_active) a++;
            if ({dplus_out, dminus_out} != 2'b10) nj++;
            if (get_tx_packet_data) g++;
            @(negedge tb_clk);
        end
    endtask

    logic [1:0] ack_syms[19];
    int e_cnt, a_cnt, nj_cnt, g_cnt, k;

    initial begin
        n_rst = 1'b0; tx_packet = 3'd0; buffer_occupancy = 7'd0; tx_packet_data = 8'h00;
        for (int j = 0; j < 4; j++) pay[j] = 8'h00;
        //            pkt   occ    b0     b1     b2     pid    bits gets stuffs crc       first
        vecs[0] = '{3'd2, 7'd0, 8'h00, 8'h00, 8'h00, 8'hD2, 19, 0, 0, 16'h0000, 0};
        vecs[1] = '{3'd3, 7'd0, 8'h00, 8'h00, 8'h00, 8'h5A, 19, 0, 0, 16'h0000, 0};
        vecs[2] = '{3'd4, 7'd0, 8'h00, 8'h00, 8'h00, 8'h1E, 19, 0, 0, 16'h0000, 0};
        vecs[3] = '{3'd1, 7'd0, 8'h00, 8'h00, 8'h00, 8'hC3, 35, 0, 0, 16'h0000, 0};
        vecs[4] = '{3'd1, 7'd1, 8'hFF, 8'h00, 8'h00, 8'hC3, 45, 1, 2, 16'hFF00, 127};
        vecs[5] = '{3'd1, 7'd3, 8'h01, 8'h02, 8'h03, 8'hC3, 59, 3, 0, 16'h9E9E, 127};
        // K=01, J=10, SE0=00
        ack_syms = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01,
                     2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01,
                     2'b00, 2'b00, 2'b10};

        repeat (3) @(negedge tb_clk);
        check("rst_dplus", dplus_out, 1);
        check("rst_dminus", dminus_out, 0);
        check("rst_active", tx_transfer_active, 0);
        check("rst_error", tx_error, 0);
        check("rst_get", get_tx_packet_data, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge tb_clk);

        for (int i = 0; i < 6; i++) begin
            pay[0] = vecs[i].b0; pay[1] = vecs[i].b1; pay[2] = vecs[i].b2; pay[3] = 8'h00;
            run_packet(vecs[i].pkt, vecs[i].occ, -1, 3'd0);
            decode();
            check($sformatf("v%0d_active_clocks", i), act_cycles, vecs[i].exp_bits * CPB);
            check($sformatf("v%0d_idle_j", i), {dplus_out, dminus_out}, 2'b10);
            check($sformatf("v%0d_gets", i), n_get, vecs[i].exp_gets);
            if (vecs[i].exp_gets > 0)
                check($sformatf("v%0d_first_get", i), get_k[0], vecs[i].exp_first_get);
            for (int j = 1; j < n_get && j < 8; j++)
                check($sformatf("v%0d_get_spacing%0d", i, j), get_k[j] - get_k[j-1], 8 * CPB);
            check($sformatf("v%0d_sync", i), dec_sync, 8'h80);
            check($sformatf("v%0d_pid", i), dec_pid, vecs[i].exp_pid);
            check($sformatf("v%0d_stuffs", i), dec_stuffs, vecs[i].exp_stuffs);
            check($sformatf("v%0d_stuff_bits", i), dec_stuff_err, 0);
            check($sformatf("v%0d_eop", i), dec_eop_ok, 1);
            check($sformatf("v%0d_no_error", i), err_seen, 0);
            if (vecs[i].pkt == 3'd1) begin
                check($sformatf("v%0d_nbytes", i), dec_nbytes, vecs[i].occ);
                for (int j = 0; j < vecs[i].occ && j < 4; j++)
                    check($sformatf("v%0d_byte%0d", i, j), dec_bytes[j], pay[j]);
                check($sformatf("v%0d_crc_table", i), dec_crc, vecs[i].exp_crc);
                check($sformatf("v%0d_crc_model", i), dec_crc, crc16_model(vecs[i].occ));
            end else begin
                check($sformatf("v%0d_nbits", i), dec_nbits, 16);
            end
            repeat (5) @(negedge tb_clk);
        end

        // exact ACK line waveform
        run_packet(3'd2, 7'd0, -1, 3'd0);
        check("ack_nsym", n_sym, 19);
        for (int j = 0; j < 19; j++)
            check($sformatf("ack_sym%0d", j), syms[j], ack_syms[j]);

        // overflow request
        @(negedge tb_clk);
        tx_packet = 3'd1; buffer_occupancy = 7'd65;
        @(negedge tb_clk);
        tx_packet = 3'd0;
        watch(20, e_cnt, a_cnt, nj_cnt, g_cnt);
        check("ovf_error_cycles", e_cnt, 1);
        check("ovf_active", a_cnt, 0);
        check("ovf_line_j", nj_cnt, 0);
        check("ovf_gets", g_cnt, 0);

        // codes 5-7 are ignored silently
        for (int c = 5; c < 8; c++) begin
            tx_packet = 3'(c); buffer_occupancy = 7'd0;
            @(negedge tb_clk);
            tx_packet = 3'd0;
            watch(10, e_cnt, a_cnt, nj_cnt, g_cnt);
            check($sformatf("code%0d_error", c), e_cnt, 0);
            check($sformatf("code%0d_active", c), a_cnt + nj_cnt, 0);
        end

        // 64 bytes is still legal; abandon it with a reset
        tx_packet = 3'd1; buffer_occupancy = 7'd64;
        @(negedge tb_clk);
        tx_packet = 3'd0;
        check("max_accept_active", tx_transfer_active, 1);
        check("max_accept_error", tx_error, 0);
        n_rst = 1'b0;
        repeat (2) @(negedge tb_clk);
        n_rst = 1'b1;
        @(negedge tb_clk);

        // reset during the PID of a NAK
        tx_packet = 3'd3; buffer_occupancy = 7'd0;
        @(negedge tb_clk);
        tx_packet = 3'd0;
        k = 0;
        while (tx_transfer_active && k < 76) begin
            k++;
            @(negedge tb_clk);
        end
        check("nak_reached_pid", k, 76);
        n_rst = 1'b0;
        #1;
        check("midrst_dplus", dplus_out, 1);
        check("midrst_dminus", dminus_out, 0);
        check("midrst_active", tx_transfer_active, 0);
        check("midrst_get", get_tx_packet_data, 0);
        repeat (3) @(negedge tb_clk);
        n_rst = 1'b1;
        watch(40, e_cnt, a_cnt, nj_cnt, g_cnt);
        check("postrst_quiet", a_cnt + nj_cnt + g_cnt + e_cnt, 0);

        // STALL with an ACK request made while busy: only the STALL goes out
        run_packet(3'd4, 7'd0, 40, 3'd2);
        decode();
        check("busy_stall_clocks", act_cycles, 19 * CPB);
        check("busy_stall_pid", dec_pid, 8'h1E);
        watch(300, e_cnt, a_cnt, nj_cnt, g_cnt);
        check("busy_no_second_packet", a_cnt, 0);
        check("busy_line_j", nj_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
